// File: rtl/fifo_rd_serializer_pkg.sv
// fifo_rd_serializer_pkg
// Shared defaults and width derivations for the FIFO read serializer.
//   DEF_DATA_WIDTH : default FIFO word width
//   DEF_OUT_WIDTH  : default output beat width
//   calc_ratio()   : beats per word (DATA_WIDTH / OUT_WIDTH)
//   calc_idx_w()   : width of the beat index counter
package fifo_rd_serializer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_OUT_WIDTH  = 8;

  function automatic int unsigned calc_ratio(int unsigned data_w, int unsigned out_w);
    return data_w / out_w;
  endfunction

  // Floor of 1 keeps the index a legal vector even for degenerate ratios.
  function automatic int unsigned calc_idx_w(int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_serializer_if.sv
// fifo_rd_serializer_if
// Output beat stream of the serializer.
//   m_valid : beat valid           (master -> slave)
//   m_ready : beat accepted        (slave  -> master)
//   m_data  : beat payload         (master -> slave)
//   m_last  : final beat of a word (master -> slave)
interface fifo_rd_serializer_if #(
  parameter int unsigned OUT_WIDTH = 8
) ();

  logic                 m_valid;
  logic                 m_ready;
  logic [OUT_WIDTH-1:0] m_data;
  logic                 m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_serializer_word_skid_buf.sv
// word_skid_buf
// Two-entry word buffer between the FIFO read port and the serializer.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push       : write i_push_data into the tail entry (caller keeps count < 2)
//   i_pop        : retire the head entry (caller keeps count > 0)
//   o_head_data  : head entry contents
//   o_count      : number of valid entries, 0..2
module word_skid_buf
  import fifo_rd_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Simultaneous push and pop leaves the count alone; only pointers move.
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_count     = r_count;

endmodule

// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer
// Reads words from a synchronous FIFO (one-cycle read latency) and emits them
// as DATA_WIDTH/OUT_WIDTH narrower beats, least significant slice first.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_fifo_empty  : upstream FIFO empty flag
//   i_fifo_data   : upstream FIFO read data, valid the cycle after a read
//   o_fifo_cs     : FIFO chip select, high whenever out of reset
//   o_fifo_rd_en  : FIFO read request
//   io_m          : output beat stream (valid/ready/data/last)
module fifo_rd_serializer
  import fifo_rd_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_fifo_empty,
  input  logic [DATA_WIDTH-1:0]  i_fifo_data,
  output logic                   o_fifo_cs,
  output logic                   o_fifo_rd_en,
  fifo_rd_serializer_if.master   io_m
);

  localparam int unsigned      RATIO    = calc_ratio(DATA_WIDTH, OUT_WIDTH);
  localparam int unsigned      IDX_W    = calc_idx_w(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if ((DATA_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("DATA_WIDTH must be a multiple (>= 2x) of OUT_WIDTH");
  end

  logic                  r_inflight;
  logic [IDX_W-1:0]      r_idx;
  logic [1:0]            w_count;
  logic [DATA_WIDTH-1:0] w_head;
  logic [2:0]            w_occupancy;
  logic                  w_rd_en;
  logic                  w_valid;
  logic                  w_xfer;
  logic                  w_pop;
  logic [OUT_WIDTH-1:0]  w_beat;

  // Reads are only issued when the word can be stored on arrival, counting
  // the one still in flight from the previous cycle.
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_rd_en     = !i_fifo_empty && (w_occupancy < 3'd2) && !i_rst;

  assign w_valid = (w_count != 2'd0) && !i_rst;
  assign w_xfer  = w_valid && io_m.m_ready;
  assign w_pop   = w_xfer && (r_idx == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight <= 1'b0;
      r_idx      <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_xfer) begin
        r_idx <= w_pop ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  word_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_skid_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (r_inflight),
    .i_push_data (i_fifo_data),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_count     (w_count)
  );

  always_comb begin
    w_beat = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_beat = w_head[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  assign io_m.m_valid = w_valid;
  assign io_m.m_data  = w_valid ? w_beat : '0;
  assign io_m.m_last  = w_valid && (r_idx == LAST_IDX);
  assign o_fifo_cs    = !i_rst;
  assign o_fifo_rd_en = w_rd_en;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// tb_fifo_rd_serializer
// Self-checking bench: a queue-based upstream FIFO model plus a byte-stream
// scoreboard built from the words pushed, with word-level occupancy tracking.
module tb_fifo_rd_serializer;

  localparam int unsigned DW    = 32;
  localparam int unsigned OW    = 8;
  localparam int unsigned RATIO = DW / OW;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_cs;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;

  always #5 clk = ~clk;

  fifo_rd_serializer_if #(.OUT_WIDTH(OW)) m_if ();

  fifo_rd_serializer #(
    .DATA_WIDTH (DW),
    .OUT_WIDTH  (OW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_cs    (fifo_cs),
    .o_fifo_rd_en (fifo_rd_en),
    .io_m         (m_if)
  );

  logic [DW-1:0] fifo_q[$];
  logic [OW-1:0] exp_data_q[$];
  bit            exp_last_q[$];
  int            tr_cyc[$];
  logic [OW-1:0] tr_data[$];
  bit            tr_last[$];

  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  int            n_reads  = 0;
  int            buf_cnt  = 0;   // words held in the adapter's buffer
  bit            rd_prev  = 0;   // a read was issued last cycle
  bit            pend_valid = 0;
  logic [DW-1:0] pend_word;
  bit            hold_prev = 0;
  logic [OW-1:0] prev_data;
  bit            rst_req  = 1;
  int            ready_pct = 100;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_word(logic [DW-1:0] w);
    fifo_q.push_back(w);
    for (int i = 0; i < RATIO; i++) begin
      exp_data_q.push_back(w[i*OW +: OW]);
      exp_last_q.push_back(i == RATIO - 1);
    end
  endtask

  task automatic clear_log();
    tr_cyc.delete();
    tr_data.delete();
    tr_last.delete();
  endtask

  // One clock cycle: inputs change 1 time unit after the rising edge, outputs
  // are checked on the falling edge.
  task automatic cycle();
    bit exp_rd;
    bit xfer;
    int pops;
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_req;
    if (pend_valid) fifo_data = pend_word;
    pend_valid = 0;
    fifo_empty = (fifo_q.size() == 0);
    m_if.m_ready = ($urandom_range(99) < ready_pct);
    @(negedge clk);
    pops = 0;
    if (rst) begin
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_valid", m_if.m_valid, 0);
      check("rst_data", m_if.m_data, 0);
      check("rst_last", m_if.m_last, 0);
      check("rst_cs", fifo_cs, 0);
      buf_cnt   = 0;
      rd_prev   = 0;
      hold_prev = 0;
    end else begin
      exp_rd = !fifo_empty && ((buf_cnt + int'(rd_prev)) < 2);
      check("rd_en", fifo_rd_en, exp_rd);
      check("cs", fifo_cs, 1);
      check("valid", m_if.m_valid, buf_cnt > 0);
      if (m_if.m_valid) begin
        if (exp_data_q.size() == 0) begin
          check("beat_underflow", m_if.m_valid, 0);
        end else begin
          check("data", m_if.m_data, exp_data_q[0]);
          check("last", m_if.m_last, exp_last_q[0]);
        end
        if (hold_prev) check("hold", m_if.m_data, prev_data);
      end else begin
        check("last_idle", m_if.m_last, 0);
      end
      xfer = m_if.m_valid && m_if.m_ready;
      if (xfer && exp_data_q.size() > 0) begin
        tr_cyc.push_back(cyc);
        tr_data.push_back(m_if.m_data);
        tr_last.push_back(m_if.m_last);
        if (exp_last_q[0]) pops = 1;
        void'(exp_data_q.pop_front());
        void'(exp_last_q.pop_front());
      end
      hold_prev = m_if.m_valid && !m_if.m_ready;
      prev_data = m_if.m_data;
      if (fifo_rd_en) begin
        n_reads++;
        if (fifo_q.size() > 0) begin
          pend_word  = fifo_q.pop_front();
          pend_valid = 1;
        end
      end
      buf_cnt = buf_cnt + int'(rd_prev) - pops;
      rd_prev = fifo_rd_en;
    end
  endtask

  // Holds reset for n cycles; the upstream FIFO is cleared alongside.
  task automatic do_reset(int n);
    rst_req = 1;
    repeat (n) cycle();
    fifo_q.delete();
    exp_data_q.delete();
    exp_last_q.delete();
    pend_valid = 0;
    rst_req = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [OW-1:0] exp_b[4];
    logic [DW-1:0] first_word;
    int            fall;
    int            pushed;

    rst          = 1;
    fifo_empty   = 1;
    fifo_data    = '0;
    m_if.m_ready = 0;

    // Reset with a non-empty FIFO: nothing may be read or emitted.
    push_word(32'h1111_1111);
    push_word(32'h2222_2222);
    do_reset(2);
    repeat (3) cycle();

    // Single word, latency and beat order.
    ready_pct = 100;
    clear_log();
    push_word(32'hDDCC_BBAA);
    fall = cyc + 1;
    repeat (8) cycle();
    exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
    check("single_beats", tr_cyc.size(), 4);
    if (tr_cyc.size() > 0) check("single_latency", tr_cyc[0] - fall, 2);
    for (int i = 0; i < tr_cyc.size() && i < 4; i++) begin
      check("single_gap", tr_cyc[i] - tr_cyc[0], i);
      check("single_data", tr_data[i], exp_b[i]);
      check("single_last", tr_last[i], i == 3);
    end

    // Back-to-back words, no bubble between them.
    clear_log();
    push_word(32'h0302_0100);
    push_word(32'h0706_0504);
    fall = cyc + 1;
    repeat (12) cycle();
    check("b2b_beats", tr_cyc.size(), 8);
    if (tr_cyc.size() > 0) check("b2b_latency", tr_cyc[0] - fall, 2);
    for (int i = 0; i < tr_cyc.size() && i < 8; i++) begin
      check("b2b_gap", tr_cyc[i] - tr_cyc[0], i);
      check("b2b_data", tr_data[i], i);
    end

    // Backpressure: four words queued, downstream stalled.
    clear_log();
    ready_pct = 0;
    n_reads   = 0;
    first_word = $urandom;
    push_word(first_word);
    for (int i = 0; i < 3; i++) push_word($urandom);
    repeat (10) cycle();
    check("bp_reads", n_reads, 2);
    check("bp_valid", m_if.m_valid, 1);
    check("bp_hold_data", m_if.m_data, first_word[OW-1:0]);
    ready_pct = 100;
    repeat (24) cycle();
    check("bp_beats", tr_cyc.size(), 16);
    check("bp_drained", exp_data_q.size(), 0);

    // Random words with 50% downstream readiness.
    ready_pct = 50;
    pushed = 0;
    for (int k = 0; k < 3000 && (pushed < 64 || exp_data_q.size() != 0); k++) begin
      if (pushed < 64 && $urandom_range(2) == 0) begin
        push_word($urandom);
        pushed++;
      end
      cycle();
    end
    check("rand_drained", exp_data_q.size(), 0);

    // Reset two beats into a word, then refill.
    ready_pct = 100;
    clear_log();
    push_word(32'hA5A4_A3A2);
    push_word(32'hB5B4_B3B2);
    for (int k = 0; k < 10 && tr_cyc.size() < 2; k++) cycle();
    check("mw_beats_before", tr_cyc.size(), 2);
    do_reset(1);
    cycle();
    check("mw_valid_after", m_if.m_valid, 0);
    clear_log();
    push_word(32'h4433_2211);
    repeat (8) cycle();
    check("mw_refill_beats", tr_cyc.size(), 4);
    if (tr_data.size() > 0) check("mw_first_byte", tr_data[0], 8'h11);
    if (tr_data.size() > 3) check("mw_last_byte", tr_data[3], 8'h44);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_serializer.md
FIFO_RD_SERIALIZER -- requirements
Module: fifo_rd_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: FIFO word width.
REQ-002 Parameter OUT_WIDTH, default 8: output beat width; DATA_WIDTH SHALL be an integer multiple of OUT_WIDTH, RATIO = DATA_WIDTH/OUT_WIDTH >= 2.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fifo_empty  input  1  empty flag of upstream synchronous FIFO.
REQ-006 fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
REQ-007 fifo_cs  output  1  FIFO chip select, tied high when out of reset.
REQ-008 fifo_rd_en  output  1  FIFO read request.
REQ-009 m_valid  output  1  output beat valid.
REQ-010 m_ready  input  1  downstream accepts beat.
REQ-011 m_data  output  OUT_WIDTH  output beat.
REQ-012 m_last  output  1  high on final beat of a word.

Function
REQ-013 Adapter SHALL hold a 2-entry word buffer (count 0..2) plus a 1-bit in-flight flag.
REQ-014 fifo_rd_en SHALL equal !fifo_empty && (count + inflight) < 2 && !rst; combinational from registered state and fifo_empty.
REQ-015 inflight SHALL be set the cycle after fifo_rd_en=1 and cleared otherwise (single-cycle flag).
REQ-016 When inflight=1, fifo_data SHALL be written into the tail buffer entry at that edge; no read is ever issued that cannot be stored.
REQ-017 m_valid SHALL be high iff count>0; m_data = head word bits [idx*OUT_WIDTH +: OUT_WIDTH], idx = beat index 0..RATIO-1, LSB slice first.
REQ-018 m_last SHALL be high iff m_valid && idx==RATIO-1.
REQ-019 Beat transfer = m_valid && m_ready; on transfer idx increments; at idx==RATIO-1 idx wraps to 0 and head word pops.
REQ-020 Capture and pop in the same cycle SHALL leave count unchanged, with correct head/tail pointer advance.
REQ-021 m_data/m_valid SHALL stay stable while m_valid && !m_ready.
REQ-022 Latency: first beat valid 2 cycles after fifo_empty falls with empty buffer (rd_en cycle N, capture edge end of N+1, m_valid cycle N+2).
REQ-023 Sustained throughput: one beat per cycle with continuous m_ready and non-empty FIFO; no bubbles between words.
REQ-024 m_ready toggling SHALL never drop, duplicate or reorder beats.

Reset
REQ-025 On rst: count=0, inflight=0, idx=0, buffer pointers=0, buffer data=0; m_valid=0, m_last=0, m_data=0, fifo_rd_en=0, fifo_cs=0.
REQ-026 Reset mid-operation discards buffered and in-flight words; upstream FIFO SHALL be reset in the same cycle by the system.
REQ-027 First fifo_rd_en after reset release no earlier than the first cycle with rst=0.

Structure
REQ-028 Shared package holds default DATA_WIDTH/OUT_WIDTH and the RATIO/index-width derivation ($clog2(RATIO)).
REQ-029 One sub-module, word_skid_buf (2-entry word buffer with count and pointers); serializer index logic stays in top.

Verification
REQ-030 Reset: rst=1 two cycles, FIFO non-empty -> fifo_rd_en=0, m_valid=0, m_data=0 throughout.
REQ-031 Single word 0xDDCCBBAA, m_ready=1 -> beats AA,BB,CC,DD on 4 consecutive cycles, m_last only with DD, first beat 2 cycles after fifo_empty falls.
REQ-032 Back-to-back 0x03020100, 0x07060504, m_ready=1 -> beats 00..07 on 8 consecutive cycles, no gap.
REQ-033 Backpressure: m_ready=0 for 10 cycles with 4 words queued -> exactly 2 reads issued, m_data held at first byte; release -> all 16 bytes in order.
REQ-034 Random m_ready (50%) over 64 random words -> scoreboard byte stream matches, no rd_en while count+inflight=2.
REQ-035 Reset asserted mid-word (after 2 beats) -> next cycle m_valid=0, idx=0; after FIFO refill, next word starts at byte 0.
